// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               the load/store unit; one outstanding transaction at a time.
//               Optional response watchdog: define MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // instruction fetch
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_err_o,
    // load/store unit
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [AW-1:0]   lsu_addr_i,
    input  logic [DW-1:0]   lsu_wdata_i,
    input  logic [DW/8-1:0] lsu_be_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [DW-1:0]   lsu_rdata_o,
    output logic            lsu_err_o,
    // memory bus
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    localparam int c_BW        = DW / 8;
    localparam int c_STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_lsu;
    logic                  r_we;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;
    logic [c_BW-1:0]       r_be;
    logic [DW-1:0]         r_rdata;
    logic [c_STARVE_W-1:0] r_starve;

    logic w_arb_en;
    logic w_if_force;
    logic w_lsu_win;
    logic w_if_win;
    logic w_cap_rdata;
    logic w_clr_rdata;
    logic w_resp_if;
    logic w_resp_lsu;

    // Grants are gated by reset so every output reads 0 while rst_ni is low.
    assign w_arb_en   = (r_state == IDLE) && rst_ni;
    assign w_if_force = if_req_i && (r_starve == c_STARVE_MAX);
    assign w_lsu_win  = w_arb_en && lsu_req_i && !w_if_force;
    assign w_if_win   = w_arb_en && if_req_i && !w_lsu_win;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               r_err;
    logic               w_tmo_hit;
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cap_rdata  = 1'b0;
        w_clr_rdata  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_tmo_hit    = 1'b0;
`endif
        if_gnt_o     = w_if_win;
        lsu_gnt_o    = w_lsu_win;
        mem_req_o    = 1'b0;
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_win || w_lsu_win) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (r_we) begin
                        w_state_nxt = RESP;
                        w_clr_rdata = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = RESP;
                    w_cap_rdata = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = RESP;
                    w_clr_rdata = 1'b1;
                    w_tmo_hit   = 1'b1;
                end
`endif
            end
            RESP: begin
                w_state_nxt  = IDLE;
                if_rvalid_o  = !r_owner_lsu;
                lsu_rvalid_o = r_owner_lsu;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are captured at grant so the requester may move on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner_lsu <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else if (w_lsu_win) begin
            r_owner_lsu <= 1'b1;
            r_we        <= lsu_we_i;
            r_addr      <= lsu_addr_i;
            r_wdata     <= lsu_we_i ? lsu_wdata_i : '0;
            r_be        <= lsu_we_i ? lsu_be_i : '1;
        end else if (w_if_win) begin
            r_owner_lsu <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= if_addr_i;
            r_wdata     <= '0;
            r_be        <= '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve <= '0;
        end else if (w_if_win) begin
            r_starve <= '0;
        end else if (w_lsu_win && if_req_i && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + c_STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_cap_rdata) begin
            r_rdata <= mem_rdata_i;
        end else if (w_clr_rdata) begin
            r_rdata <= '0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Counts WAIT cycles without a response; cleared whenever WAIT is left.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == WAIT) && (w_state_nxt == WAIT)) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
            if (w_cap_rdata || w_clr_rdata) begin
                r_err <= w_tmo_hit;
            end
        end
    end
`endif

    assign w_resp_if  = (r_state == RESP) && !r_owner_lsu;
    assign w_resp_lsu = (r_state == RESP) && r_owner_lsu;

    assign if_rdata_o  = w_resp_if  ? r_rdata : '0;
    assign lsu_rdata_o = w_resp_lsu ? r_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    assign if_err_o  = w_resp_if  && r_err;
    assign lsu_err_o = w_resp_lsu && r_err;
`else
    assign if_err_o  = 1'b0;
    assign lsu_err_o = 1'b0;
`endif

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_be_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    mem_arbiter #(
        .AW             (32),
        .DW             (32),
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_err_o     (if_err_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_be_i     (lsu_be_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  who;    // {if_rvalid, lsu_rvalid}
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    bit          gnt_log[$];   // 1 = fetch grant, 0 = LSU grant
    int          n_vec;
    int          n_err;
    int          stall_cfg;
    int          st_cnt;
    bit          pend;
    bit          drop_rv;
    bit          expect_tmo;
    logic [31:0] pend_data;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory model: grants after stall_cfg cycles, load data one cycle later.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        st_cnt       = 0;
        pend         = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (!rst_ni) begin
                st_cnt = 0;
                pend   = 1'b0;
            end else begin
                if (pend) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend_data;
                    pend         = 1'b0;
                end
                if (mem_req_o) begin
                    if (st_cnt >= stall_cfg) begin
                        mem_gnt_i = 1'b1;
                        st_cnt    = 0;
                        if (!mem_we_o && !drop_rv) begin
                            pend      = 1'b1;
                            pend_data = mdata(mem_addr_o);
                        end
                    end else begin
                        st_cnt++;
                    end
                end
            end
        end
    end

    // Scoreboard: push expectation at grant, pop and compare at response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (if_gnt_o || lsu_gnt_o) begin
                    chk("one_gnt", 64'(if_gnt_o && lsu_gnt_o), 64'(0));
                    if (lsu_gnt_o) begin
                        m_e.who   = 2'b01;
                        m_e.err   = expect_tmo && !lsu_we_i;
                        m_e.rdata = (lsu_we_i || expect_tmo) ? 32'h0 : mdata(lsu_addr_i);
                        gnt_log.push_back(1'b0);
                    end else begin
                        m_e.who   = 2'b10;
                        m_e.err   = expect_tmo;
                        m_e.rdata = expect_tmo ? 32'h0 : mdata(if_addr_i);
                        gnt_log.push_back(1'b1);
                    end
                    exp_q.push_back(m_e);
                end
                if (if_rvalid_o || lsu_rvalid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rvalid", 64'({if_rvalid_o, lsu_rvalid_o}), 64'(0));
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("rsp_owner", 64'({if_rvalid_o, lsu_rvalid_o}), 64'(m_e.who));
                        if (m_e.who == 2'b10) begin
                            chk("rsp_rdata", 64'(if_rdata_o), 64'(m_e.rdata));
                            chk("rsp_err", 64'(if_err_o), 64'(m_e.err));
                            chk("rsp_other", 64'({lsu_err_o, lsu_rdata_o}), 64'(0));
                        end else begin
                            chk("rsp_rdata", 64'(lsu_rdata_o), 64'(m_e.rdata));
                            chk("rsp_err", 64'(lsu_err_o), 64'(m_e.err));
                            chk("rsp_other", 64'({if_err_o, if_rdata_o}), 64'(0));
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input bit is_if, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        if (is_if) begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end else begin
            lsu_req_i   = 1'b1;
            lsu_we_i    = we;
            lsu_addr_i  = addr;
            lsu_wdata_i = wdata;
            lsu_be_i    = be;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = is_if ? if_gnt_o : lsu_gnt_o;
        end
        chk("gnt_wait", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit seen;
        n_vec       = 0;
        n_err       = 0;
        stall_cfg   = 0;
        drop_rv     = 1'b0;
        expect_tmo  = 1'b0;
        rst_ni      = 1'b1;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0;
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;
        lsu_be_i    = 4'h0;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_ctrl", 64'({if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o,
                             lsu_err_o, mem_req_o, mem_we_o, mem_be_o}), 64'(0));
        chk("rst_rdata", {if_rdata_o, lsu_rdata_o}, 64'(0));
        chk("rst_mem", {mem_addr_o, mem_wdata_o}, 64'(0));
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Single load: T1 bus fields, response at T3.
        issue(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        chk("ld_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o}), 64'({1'b1, 1'b0, 4'hF, 32'h100}));
        @(negedge clk);
        chk("ld_t2", 64'({lsu_rvalid_o, mem_req_o}), 64'(0));
        @(negedge clk);
        chk("ld_t3", 64'(lsu_rvalid_o), 64'(1));
        drain();

        // Store with three stall cycles; requester fields change after grant.
        stall_cfg = 3;
        issue(1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'h3);
        lsu_addr_i  = 32'hFFFF_FFFF;
        lsu_wdata_i = 32'hA5A5_A5A5;
        lsu_be_i    = 4'hC;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o}), 64'({1'b1, 1'b1, 4'h3, 32'h200}));
            chk("st_wdata", 64'(mem_wdata_o), 64'(32'h1234_5678));
        end
        @(negedge clk);
        chk("st_ack", 64'(lsu_rvalid_o), 64'(1));
        drain();
        stall_cfg = 0;

        // Simultaneous requests: LSU first, fetch in the next IDLE.
        @(posedge clk);
        #1;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h40;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h300;
        @(negedge clk);
        chk("sim_gnt", 64'({if_gnt_o, lsu_gnt_o}), 64'(2'b01));
        @(posedge clk);
        #1 lsu_req_i = 1'b0;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            seen = if_gnt_o;
        end
        chk("sim_if_lat", 64'(c), 64'(4));
        @(posedge clk);
        #1 if_req_i = 1'b0;
        drain();

        // Starvation: both requesters held high for ten grants.
        gnt_log.delete();
        @(posedge clk);
        #1;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h80;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h180;
        for (int i = 0; i < 300 && gnt_log.size() < 10; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
        drain();
        chk("starve_cnt", 64'(gnt_log.size()), 64'(10));
        for (int i = 0; i < 10 && i < gnt_log.size(); i++) begin
            chk("starve_seq", 64'(gnt_log[i]), 64'((i % 5) == 4));
        end

        // Reset in WAIT: outputs clear at once, no late response.
        drop_rv = 1'b1;
        issue(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        @(posedge clk);
        #3;
        rst_ni    = 1'b0;
        if_req_i  = 1'b1;
        lsu_req_i = 1'b1;
        #1;
        chk("mrst_ctrl", 64'({if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o,
                              lsu_err_o, mem_req_o, mem_we_o, mem_be_o}), 64'(0));
        chk("mrst_rdata", {if_rdata_o, lsu_rdata_o}, 64'(0));
        chk("mrst_mem", {mem_addr_o, mem_wdata_o}, 64'(0));
        exp_q.delete();
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        drop_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mrst_quiet", 64'({if_rvalid_o, lsu_rvalid_o, mem_req_o}), 64'(0));
        end
        issue(1'b0, 1'b1, 32'h600, 32'hCAFE_F00D, 4'hF);
        drain();
        issue(1'b1, 1'b0, 32'h640, 32'h0, 4'h0);
        drain();

`ifdef MEM_ARB_TIMEOUT_EN
        // Load that never completes: error response after 8 WAIT cycles.
        drop_rv    = 1'b1;
        expect_tmo = 1'b1;
        issue(1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            seen = if_rvalid_o;
        end
        chk("tmo_lat", 64'(c), 64'(10));
        drain();
        drop_rv    = 1'b0;
        expect_tmo = 1'b0;
        issue(1'b1, 1'b0, 32'h740, 32'h0, 4'h0);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-port data/instruction memory between two requesters.
  - Instruction fetch (`if_*`).
  - Load/store path (`lsu_*`), driven by the control decoder's mem_read/mem_write.
- Grants one transaction at a time and forwards it to the memory bus through a request/grant/response handshake.
- Returns the read data or write acknowledge to the owning requester.
- Sits between the core pipeline and the memory; the core stalls on its `ready`/`rvalid` handshakes.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- STARVE_LIMIT, 4, consecutive LSU grants with fetch pending before fetch is forced
- TIMEOUT_CYCLES, 255, response watchdog limit (only with MEM_ARB_TIMEOUT_EN)

Ports (one clock `clk_i`; reset `rst_ni` is asynchronous and active-low):
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request valid
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DW  fetch read data
- if_err_o  out  1  fetch response error
- lsu_req_i  in  1  load/store request valid
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  AW  load/store address
- lsu_wdata_i  in  DW  store data
- lsu_be_i  in  DW/8  store byte enables
- lsu_gnt_o  out  1  LSU request accepted this cycle
- lsu_rvalid_o  out  1  LSU response valid (1-cycle pulse; stores return ack)
- lsu_rdata_o  out  DW  load data (0 for stores)
- lsu_err_o  out  1  LSU response error
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_be_o  out  DW/8  memory byte enables (all ones for reads)
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DW  memory read data

## Operation
- States: IDLE, REQ, WAIT, RESP. Owner register records IF or LSU.
- IDLE:
  - Arbitrate. LSU has priority.
  - Exception: fetch wins when `if_req_i` is high and the starve counter has reached STARVE_LIMIT.
  - The grant (`*_gnt_o`) is combinational, driven in the same cycle as the winning request.
  - On grant, latch addr/we/wdata/be and owner, then go to REQ.
- Starve counter:
  - Increments on each LSU grant while `if_req_i` is high.
  - Clears on a fetch grant.
  - Saturates at STARVE_LIMIT.
- REQ:
  - `mem_req_o`=1, driven from the latched fields. All fields stay stable until `mem_gnt_i`.
  - `mem_gnt_i` on a store: go to RESP as an ack, with rdata=0.
  - `mem_gnt_i` on a load: go to WAIT.
- WAIT:
  - On `mem_rvalid_i`, capture `mem_rdata_i` and go to RESP.
  - `mem_rvalid_i` in any other state is ignored.
- RESP:
  - Assert the owner's `*_rvalid_o` for exactly one cycle, with the registered rdata/err.
  - Go to IDLE.
- Requesters hold req and fields stable until gnt. A requester deasserting req before gnt is legal: no transaction occurs.
- The non-owner's rvalid/err are always 0.

## Timing
- Reset values:
  - State IDLE, owner IF, starve counter 0, timeout counter 0.
  - All `*_o` outputs 0.
  - Reset mid-transaction abandons it; no rvalid is issued.
- Load latency, zero memory wait states:
  - gnt at T0, `mem_req_o` at T1, `mem_gnt_i` at T1.
  - `mem_rvalid_i` at T2, `*_rvalid_o` at T3.
- Store latency: gnt at T0, `mem_gnt_i` at T1, `*_rvalid_o` at T2.
- Each memory stall cycle adds one cycle.
- At most one outstanding transaction.
- The next grant is possible in the cycle after RESP, i.e. in IDLE.
- A simultaneous `if_req_i` and `lsu_req_i` in IDLE produces exactly one gnt.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - It reaches TIMEOUT_CYCLES when no `mem_rvalid_i` arrives in TIMEOUT_CYCLES consecutive WAIT cycles. On that cycle, go to RESP with err=1 and rdata=0.
  - The counter clears on leaving WAIT.
  - Memory must not respond to an aborted load.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - `if_err_o`/`lsu_err_o` are constant 0.

## Test plan
- **Single load:**
  - Stimulus: `lsu_req_i`=1, we=0, addr=0x100; memory grants immediately; rvalid next cycle with rdata=0xDEADBEEF.
  - Required: `lsu_gnt_o` at T0, `mem_addr_o`=0x100 with `mem_be_o`=0xF at T1, `lsu_rvalid_o`=1 with rdata=0xDEADBEEF at T3.
- **Store with stall:**
  - Stimulus: we=1, wdata=0x12345678, be=0x3; `mem_gnt_i` held low for 3 cycles.
  - Required: `mem_req_o` and fields stable for 4 cycles, `lsu_rvalid_o` one cycle after `mem_gnt_i`, rdata=0.
- **Simultaneous requests:**
  - Stimulus: both requests high.
  - Required: LSU granted first; fetch granted in the next IDLE once the LSU drops its request.
- **Starvation:**
  - Stimulus: both requests continuously high, STARVE_LIMIT=4.
  - Required: grant sequence LSU×4, IF, LSU×4, IF.
- **Reset mid-WAIT:**
  - Stimulus: assert `rst_ni`=0 during WAIT.
  - Required: all outputs 0 immediately; no rvalid after release; a new request is served normally.
- **Timeout (with MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):**
  - Stimulus: a load that never receives rvalid.
  - Required: `if_rvalid_o`=1, `if_err_o`=1, rdata=0 after 8 WAIT cycles.
